// File: rtl/r4_srt_iter_ctrl.sv
// Radix-4 SRT fraction divider core: constant-threshold digit selection, on-the-fly quotient, final sign fix.
// Latency: accept at cycle 0, out_valid_o high at cycle ITERS+2; one operation per ITERS+3 cycles.
// Backpressure: result held stable in DONE until out_ready_i; start_ready_o only in IDLE and masked by flush_i.
module r4_srt_iter_ctrl #(
  parameter  int WIDTH = 54,
  parameter  int ITERS = 27,
  localparam int REM_W = WIDTH + 2,
  localparam int QUO_W = 2 * ITERS + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [REM_W-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [QUO_W-1:0] quo_o,
  output logic [REM_W-1:0] rem_o,
  output logic             rem_zero_o,
  output logic             busy_o
);

  localparam int CNT_W = (ITERS > 2) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_POST, S_DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [REM_W-1:0]   rem_q;
  logic [WIDTH-1:0]   d_q;
  logic [QUO_W-1:0]   q_q;
  logic [QUO_W-1:0]   qm_q;
  logic [QUO_W-1:0]   quo_q;
  logic               rem_zero_q;
  logic               out_valid_q;

  // Datapath signals
  logic [REM_W-1:0]   d_ext;
  logic signed [5:0]  est;
  logic [4:0]         q_oh;      // {-2,-1,0,+1,+2}
  logic [1:0]         q_dig;
  logic [1:0]         qm_dig;
  logic               q_from_qm;
  logic               qm_from_q;
  logic [REM_W-1:0]   mult;
  logic               sub;
  logic [REM_W-1:0]   rem_d;
  logic [QUO_W-1:0]   q_src;
  logic [QUO_W-1:0]   qm_src;
  logic [QUO_W-1:0]   q_d;
  logic [QUO_W-1:0]   qm_d;
  logic [REM_W-1:0]   rem_fix;
  logic [REM_W-1:0]   rem_corr;

  assign d_ext = {2'b00, d_q};

  // Digit selection: top 6 bits of 4*rem (1/8 units) against constant thresholds
  always_comb begin
    est  = $signed(rem_q[REM_W-3 -: 6]);
    q_oh = 5'b00100;
    if (est >= 6'sd12)       q_oh = 5'b00001;
    else if (est >= 6'sd3)   q_oh = 5'b00010;
    else if (est >= -6'sd4)  q_oh = 5'b00100;
    else if (est >= -6'sd13) q_oh = 5'b01000;
    else                     q_oh = 5'b10000;
  end

  // Divisor multiple mux and on-the-fly conversion digits for the selected q
  always_comb begin
    q_dig     = 2'd0;
    qm_dig    = 2'd3;
    q_from_qm = 1'b0;
    qm_from_q = 1'b0;
    mult      = '0;
    sub       = 1'b0;
    case (q_oh)
      5'b00001: begin q_dig = 2'd2; qm_dig = 2'd1; qm_from_q = 1'b1; mult = d_ext << 1; sub = 1'b1; end
      5'b00010: begin q_dig = 2'd1; qm_dig = 2'd0; qm_from_q = 1'b1; mult = d_ext;      sub = 1'b1; end
      5'b01000: begin q_dig = 2'd3; qm_dig = 2'd2; q_from_qm = 1'b1; mult = d_ext;      end
      5'b10000: begin q_dig = 2'd2; qm_dig = 2'd1; q_from_qm = 1'b1; mult = d_ext << 1; end
      default:  begin end
    endcase
  end

  // Single adder: subtracting a positive multiple uses inverted operand plus carry-in
  assign rem_d  = {rem_q[REM_W-3:0], 2'b00} + (sub ? ~mult : mult) + {{(REM_W-1){1'b0}}, sub};
  assign q_src  = q_from_qm ? qm_q : q_q;
  assign qm_src = qm_from_q ? q_q : qm_q;
  assign q_d    = {q_src[QUO_W-3:0], q_dig};
  assign qm_d   = {qm_src[QUO_W-3:0], qm_dig};

  // Negative final remainder: take Q-1 (held in QM) and add d back
  assign rem_fix  = rem_q + d_ext;
  assign rem_corr = rem_q[REM_W-1] ? rem_fix : rem_q;

  // Control FSM and all architectural state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      d_q         <= '0;
      q_q         <= '0;
      qm_q        <= '1;
      quo_q       <= '0;
      rem_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid_i) begin
            rem_q   <= dividend_i;
            d_q     <= divisor_i;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          qm_q  <= qm_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_POST;
        end
        S_POST: begin
          quo_q       <= rem_q[REM_W-1] ? qm_q : q_q;
          rem_q       <= rem_corr;
          rem_zero_q  <= (rem_corr == '0);
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_ready_o = (state_q == S_IDLE) && !flush_i;
  assign busy_o        = (state_q != S_IDLE);
  assign out_valid_o   = out_valid_q;
  assign quo_o         = quo_q;
  assign rem_o         = rem_q;
  assign rem_zero_o    = rem_zero_q;

endmodule
